// File: rtl/addr_gen_pkg.sv
// Shared state encoding and default widths for the DRAM address generator.
package addr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int AW_DEFAULT = 16;
    localparam int OW_DEFAULT = 6;
    localparam int SW_DEFAULT = 8;
    localparam int CW_DEFAULT = 8;

endpackage

// File: rtl/sext_adder.sv
// Sign-extends an NW-bit value to AW bits and adds it to an AW-bit base, wrapping modulo 2^AW.
module sext_adder #(
    parameter int AW = 16,
    parameter int NW = 6
) (
    input  logic [AW-1:0] i_base,
    input  logic [NW-1:0] i_val,
    output logic [AW-1:0] o_sum
);

    logic [AW-1:0] w_ext;

    assign w_ext = AW'($signed(i_val));
    assign o_sum = i_base + w_ext;

endmodule

// File: rtl/addr_gen_unit.sv
// DRAM address generator: PC load, base+offset load and strided bursts with memReady handshake.
// Optional upper-bound fault checking on burst addresses is enabled with ADDR_GEN_BOUND_EN.
module addr_gen_unit
    import addr_gen_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int OW = OW_DEFAULT,
    parameter int SW = SW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          Clk1,
    input  logic          Rst,
    input  logic          setPC,
    input  logic [AW-1:0] PC,
    input  logic          updateAddr,
    input  logic [AW-1:0] addrBase,
    input  logic [OW-1:0] offset,
    input  logic          start,
    input  logic [SW-1:0] stride,
    input  logic [CW-1:0] count,
    input  logic          memReady,
`ifdef ADDR_GEN_BOUND_EN
    input  logic [AW-1:0] limit,
    output logic          fault,
`endif
    output logic [AW-1:0] addr,
    output logic          addrValid,
    output logic          busy,
    output logic          done
);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_remaining;
    logic [SW-1:0] r_stride;
    logic          r_addrValid;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] w_baseSum;
    logic [AW-1:0] w_strideSum;

    sext_adder #(.AW(AW), .NW(OW)) u_baseAdd (
        .i_base (addrBase),
        .i_val  (offset),
        .o_sum  (w_baseSum)
    );

    sext_adder #(.AW(AW), .NW(SW)) u_strideAdd (
        .i_base (r_addr),
        .i_val  (r_stride),
        .o_sum  (w_strideSum)
    );

`ifdef ADDR_GEN_BOUND_EN
    logic r_fault;
    logic w_startOver;
    logic w_stepOver;

    assign w_startOver = (w_baseSum > limit);
    assign w_stepOver  = (w_strideSum > limit);
    assign fault       = r_fault;
`else
    logic w_startOver;
    logic w_stepOver;

    assign w_startOver = 1'b0;
    assign w_stepOver  = 1'b0;
`endif

    // setPC overrides everything and silently abandons any burst; done is cleared by default each cycle.
    always_ff @(posedge Clk1 or posedge Rst) begin
        if (Rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_stride    <= '0;
            r_addrValid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef ADDR_GEN_BOUND_EN
            r_fault     <= 1'b0;
`endif
        end else if (setPC) begin
            r_state     <= IDLE;
            r_addr      <= PC;
            r_remaining <= '0;
            r_addrValid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef ADDR_GEN_BOUND_EN
            r_fault     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (updateAddr) begin
                        r_addr <= w_baseSum;
                    end else if (start) begin
                        if (count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (w_startOver) begin
`ifdef ADDR_GEN_BOUND_EN
                            r_fault <= 1'b1;
`endif
                        end else begin
                            r_addr      <= w_baseSum;
                            r_stride    <= stride;
                            r_remaining <= count;
                            r_addrValid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (memReady) begin
                        if (r_remaining > CW'(1) && !w_stepOver) begin
                            r_addr      <= w_strideSum;
                            r_remaining <= r_remaining - CW'(1);
                        end else begin
                            // Either the last beat was accepted or the next address overran the limit.
                            r_addrValid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_remaining <= '0;
                            if (r_remaining > CW'(1)) begin
                                r_state <= IDLE;
`ifdef ADDR_GEN_BOUND_EN
                                r_fault <= 1'b1;
`endif
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign addr      = r_addr;
    assign addrValid = r_addrValid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_addr_gen_unit.sv
// Scoreboard testbench for addr_gen_unit; stimulus queues expected beats/done pulses, a negedge monitor checks them.
// Exercises the bound-fault path when ADDR_GEN_BOUND_EN is defined.
module tb_addr_gen_unit;

    localparam int AW = 16;
    localparam int OW = 6;
    localparam int SW = 8;
    localparam int CW = 8;

    typedef struct packed {
        logic          isDone;
        logic [AW-1:0] addr;
    } ev_t;

    logic          Clk1 = 1'b0;
    logic          Rst = 1'b0;
    logic          setPC = 1'b0;
    logic [AW-1:0] PC = '0;
    logic          updateAddr = 1'b0;
    logic [AW-1:0] addrBase = '0;
    logic [OW-1:0] offset = '0;
    logic          start = 1'b0;
    logic [SW-1:0] stride = '0;
    logic [CW-1:0] count = '0;
    logic          memReady = 1'b0;
    logic [AW-1:0] addr;
    logic          addrValid;
    logic          busy;
    logic          done;
`ifdef ADDR_GEN_BOUND_EN
    logic [AW-1:0] limit = '1;
    logic          fault;
`endif

    ev_t expQ[$];
    ev_t monEv;
    int  checks = 0;
    int  errors = 0;

    addr_gen_unit #(.AW(AW), .OW(OW), .SW(SW), .CW(CW)) dut (
        .Clk1       (Clk1),
        .Rst        (Rst),
        .setPC      (setPC),
        .PC         (PC),
        .updateAddr (updateAddr),
        .addrBase   (addrBase),
        .offset     (offset),
        .start      (start),
        .stride     (stride),
        .count      (count),
        .memReady   (memReady),
`ifdef ADDR_GEN_BOUND_EN
        .limit      (limit),
        .fault      (fault),
`endif
        .addr       (addr),
        .addrValid  (addrValid),
        .busy       (busy),
        .done       (done)
    );

    always #5 Clk1 = ~Clk1;

    task automatic checkOutput(input string name, input logic [AW-1:0] actual, input logic [AW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge Clk1);
        #1;
    endtask

    task automatic pushBeat(input logic [AW-1:0] a);
        ev_t e;
        e.isDone = 1'b0;
        e.addr   = a;
        expQ.push_back(e);
    endtask

    task automatic pushDone;
        ev_t e;
        e.isDone = 1'b1;
        e.addr   = '0;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [AW-1:0] base, input logic [OW-1:0] off,
                                 input logic [SW-1:0] str, input logic [CW-1:0] cnt);
        addrBase = base;
        offset   = off;
        stride   = str;
        count    = cnt;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (!(expQ.size() == 0 && busy === 1'b0 && done === 1'b0) && n < 60) begin
            tick();
            n++;
        end
        checkOutput(name, AW'(n < 60), AW'(1));
    endtask

    // Every live beat or done pulse must match the head of the expected queue.
    always @(negedge Clk1) begin
        if (Rst === 1'b0 && (addrValid === 1'b1 || done === 1'b1)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected output: addrValid=%0b done=%0b addr=%h, expected none",
                         addrValid, done, addr);
            end else begin
                monEv = expQ.pop_front();
                checkOutput("scoreboard kind(done)", AW'(done), AW'(monEv.isDone));
                if (!monEv.isDone) checkOutput("scoreboard addr", addr, monEv.addr);
            end
        end
    end

    initial begin
        #2 Rst = 1'b1;
        tick();
        checkOutput("reset addr", addr, 16'h0000);
        checkOutput("reset addrValid", AW'(addrValid), 16'h0);
        checkOutput("reset busy", AW'(busy), 16'h0);
        checkOutput("reset done", AW'(done), 16'h0);
        Rst = 1'b0;
        tick();

        setPC = 1'b1;
        PC    = 16'h1234;
        tick();
        setPC = 1'b0;
        checkOutput("setPC addr", addr, 16'h1234);
        checkOutput("setPC addrValid", AW'(addrValid), 16'h0);

        updateAddr = 1'b1;
        addrBase   = 16'h0100;
        offset     = 6'h3F;
        tick();
        updateAddr = 1'b0;
        checkOutput("updateAddr addr", addr, 16'h00FF);
        checkOutput("updateAddr addrValid", AW'(addrValid), 16'h0);

        // 3-beat burst, stride -2, updateAddr and addrBase changes ignored mid-burst
        memReady = 1'b1;
        pushBeat(16'h0204);
        pushBeat(16'h0202);
        pushBeat(16'h0200);
        pushDone();
        applyStimulus(16'h0200, 6'd4, 8'hFE, 8'd3);
        checkOutput("burst first addrValid", AW'(addrValid), 16'h1);
        checkOutput("burst busy", AW'(busy), 16'h1);
        updateAddr = 1'b1;
        addrBase   = 16'h5555;
        tick();
        updateAddr = 1'b0;
        tick();
        tick();
        checkOutput("burst done at N+1", AW'(done), 16'h1);
        checkOutput("burst busy after", AW'(busy), 16'h0);
        checkOutput("burst addrValid after", AW'(addrValid), 16'h0);
        waitIdle("burst completes");

        // Stall beat 2 for two cycles
        pushBeat(16'h0204);
        pushBeat(16'h0202);
        pushBeat(16'h0202);
        pushBeat(16'h0202);
        pushBeat(16'h0200);
        pushDone();
        applyStimulus(16'h0200, 6'd4, 8'hFE, 8'd3);
        addrBase = 16'h7777;
        count    = 8'd9;
        stride   = 8'h10;
        tick();
        memReady = 1'b0;
        tick();
        tick();
        memReady = 1'b1;
        waitIdle("stalled burst completes");

        pushBeat(16'hFFFE);
        pushBeat(16'h0000);
        pushDone();
        applyStimulus(16'hFFFE, 6'd0, 8'd2, 8'd2);
        waitIdle("wrap burst completes");

        pushDone();
        applyStimulus(16'h0100, 6'd0, 8'd1, 8'd0);
        checkOutput("count0 addrValid", AW'(addrValid), 16'h0);
        checkOutput("count0 done", AW'(done), 16'h1);
        waitIdle("count0 completes");

        // setPC (with updateAddr) aborts a 4-beat burst during beat 2
        pushBeat(16'h0300);
        pushBeat(16'h0304);
        applyStimulus(16'h0300, 6'd0, 8'd4, 8'd4);
        tick();
        setPC      = 1'b1;
        updateAddr = 1'b1;
        PC         = 16'hABCD;
        tick();
        setPC      = 1'b0;
        updateAddr = 1'b0;
        checkOutput("abort addr", addr, 16'hABCD);
        checkOutput("abort busy", AW'(busy), 16'h0);
        checkOutput("abort addrValid", AW'(addrValid), 16'h0);
        repeat (6) tick();
        checkOutput("abort no done", AW'(done), 16'h0);

`ifdef ADDR_GEN_BOUND_EN
        limit = 16'h0203;
        pushBeat(16'h0202);
        pushBeat(16'h0203);
        applyStimulus(16'h0202, 6'd0, 8'd1, 8'd3);
        tick();
        tick();
        checkOutput("bound fault", AW'(fault), 16'h1);
        checkOutput("bound busy", AW'(busy), 16'h0);
        checkOutput("bound addrValid", AW'(addrValid), 16'h0);
        repeat (3) tick();
        checkOutput("bound fault sticky", AW'(fault), 16'h1);
        setPC = 1'b1;
        PC    = 16'h0000;
        tick();
        setPC = 1'b0;
        checkOutput("bound fault cleared", AW'(fault), 16'h0);
        limit = '1;
`endif

        // Asynchronous reset in the middle of a cycle while a burst is live
        applyStimulus(16'h0400, 6'd0, 8'd1, 8'd4);
        #2 Rst = 1'b1;
        #1;
        checkOutput("async reset addr", addr, 16'h0000);
        checkOutput("async reset addrValid", AW'(addrValid), 16'h0);
        checkOutput("async reset busy", AW'(busy), 16'h0);
        checkOutput("async reset done", AW'(done), 16'h0);
        tick();
        Rst = 1'b0;
        repeat (5) tick();
        checkOutput("queue drained", AW'(expQ.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
